calc_result_bcd: RTL and testbench

- Sequential output stage placed directly downstream of the calculator.
- Takes one signed NB-bit calculator result, checks it against a DIGITS-digit decimal display range, and produces sign-magnitude packed BCD for the display driver.
- Conversion is iterative double-dabble, one magnitude bit per clock, using a ready/start request and a one-cycle out_valid completion pulse.

---
 rtl/calc_result_bcd.sv | 99 +++++++++
 tb/tb_calc_result_bcd.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/calc_result_bcd.sv
// calc_result_bcd: signed calculator result -> range-checked sign-magnitude packed BCD
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, result     conversion request (taken when ready=1) and signed NB-bit value
//   ready             high while idle and able to accept start
//   out_valid         one-cycle pulse when neg/overflow/bcd update
//   neg, overflow     sign of result, magnitude exceeds DIGITS decimal digits
//   bcd               packed BCD magnitude, digit 0 in bits [3:0]
module calc_result_bcd #(
    parameter int NB     = 64,
    parameter int DIGITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NB-1:0]       result,
    output logic                ready,
    output logic                out_valid,
    output logic                neg,
    output logic                overflow,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(NB);

    function automatic logic [NB-1:0] max_display();
        logic [NB-1:0] p = NB'(1);
        for (int i = 0; i < DIGITS; i++) p = p * NB'(10);
        return p - NB'(1);
    endfunction

    localparam logic [NB-1:0] MAX = max_display();

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        r_state, w_next;
    logic [NB-1:0] r_mag, w_mag;
    logic [BW-1:0] r_acc, w_adj;
    logic [CW-1:0] r_cnt;
    logic          r_neg, r_ovf, w_accept, w_ovf;

    // No wrap for the most negative value: its negation is 2^(NB-1) as unsigned.
    assign w_mag    = result[NB-1] ? -result : result;
    assign w_ovf    = w_mag > MAX;
    // The out_valid cycle is spent in IDLE but is not yet ready for a new request.
    assign ready    = (r_state == IDLE) && !out_valid;
    assign w_accept = start && ready;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? r_acc[4*d +: 4] + 4'd3 : r_acc[4*d +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = w_ovf ? DONE : CONV;
            CONV:    if (r_cnt == CW'(NB - 1)) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            neg       <= 1'b0;
            overflow  <= 1'b0;
            bcd       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (w_accept) begin
                r_mag <= w_mag;
                r_neg <= result[NB-1];
                r_ovf <= w_ovf;
                r_acc <= '0;
                r_cnt <= '0;
            end
            if (r_state == CONV) begin
                {r_acc, r_mag} <= {w_adj, r_mag} << 1;
                r_cnt          <= r_cnt + CW'(1);
            end
            if (r_state == DONE) begin
                out_valid <= 1'b1;
                neg       <= r_neg;
                overflow  <= r_ovf;
                bcd       <= r_ovf ? '0 : r_acc;
            end
        end
    end
endmodule

// File: tb/tb_calc_result_bcd.sv
// tb_calc_result_bcd: directed scoreboard bench for calc_result_bcd
module tb_calc_result_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] result = '0;
    logic        ready, out_valid, neg, overflow;
    logic [47:0] bcd;

    calc_result_bcd #(.NB(64), .DIGITS(12)) dut (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .ready(ready), .out_valid(out_valid), .neg(neg),
        .overflow(overflow), .bcd(bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] bcd;
        logic        neg;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bcd", 64'(bcd), 64'(e.bcd));
                chk("neg", 64'(neg), 64'(e.neg));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("ready_in_valid", 64'(ready), 64'd0);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic send(input logic [63:0] val, input logic [47:0] eb, input logic en, input logic eo);
        exp_t e;
        wait_ready();
        start  = 1'b1;
        result = val;
        e.bcd  = eb;
        e.neg  = en;
        e.ovf  = eo;
        e.cyc  = cyc + (eo ? 2 : 66);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        int hi = 0;
        while (q.size() > 0 && t < 300) begin
            if (ready) hi++;
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 64'(q.size()), 64'd0);
        chk("ready_busy", 64'(hi), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_neg", 64'(neg), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'd1);

        send(64'd100000000000, 48'h100000000000, 1'b0, 1'b0);
        wait_done();
        send(64'd999999999999, 48'h999999999999, 1'b0, 1'b0);
        wait_done();
        send(-64'sd999999999999, 48'h999999999999, 1'b1, 1'b0);
        wait_done();
        send(64'd1000000000000, 48'h0, 1'b0, 1'b1);
        wait_done();
        send(-64'sd1000000000000, 48'h0, 1'b1, 1'b1);
        wait_done();
        send(64'h8000000000000000, 48'h0, 1'b1, 1'b1);
        wait_done();
        send(-64'sd10, 48'h000000000010, 1'b1, 1'b0);
        wait_done();

        send(64'd0, 48'h0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        start  = 1'b1;
        result = 64'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("no_extra_valid", 64'(q.size()), 64'd0);

        send(64'd123, 48'h000000000123, 1'b0, 1'b0);
        wait_done();
        send(64'd456, 48'h000000000456, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rst    = 1'b1;
        start  = 1'b1;
        result = 64'd9;
        @(negedge clk);
        q.delete();
        rst   = 1'b0;
        start = 1'b0;
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_bcd", 64'(bcd), 64'd0);
        chk("mid_rst_neg", 64'(neg), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        chk("rst_start_ignored", 64'(ready), 64'd1);

        send(64'd7, 48'h000000000007, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
